// File: rtl/qdr_align_pkg.sv
package qdr_align_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SEARCH,
    ST_SLIP,
    ST_LOCKED
  } align_state_t;

  localparam int unsigned S_RISE0  = 0;
  localparam int unsigned S_RISE90 = 1;
  localparam int unsigned S_FALL0  = 2;
  localparam int unsigned S_FALL90 = 3;
  localparam int unsigned SAMPLES  = 4;

  function automatic int unsigned bit_index(input int unsigned c,
                                            input int unsigned i,
                                            input int unsigned s,
                                            input int unsigned width);
    return ((c * width + i) * SAMPLES) + s;
  endfunction

endpackage

// File: rtl/qdr_align_ch.sv
module qdr_align_ch
  import qdr_align_pkg::*;
#(
  parameter int unsigned WIDTH         = 8,
  parameter logic [3:0]  TRAIN_PATTERN = 4'b0011,
  parameter int unsigned MATCH_CYCLES  = 16,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     align_start,
  input  logic [WIDTH*SAMPLES-1:0] prev_word,
  input  logic [WIDTH*SAMPLES-1:0] din_word,
  output logic [WIDTH*SAMPLES-1:0] dout_word,
  output logic [1:0]               offset,
  output logic                     locked,
  output logic                     fail
);

  localparam int unsigned MC_W = $clog2(MATCH_CYCLES + 1);
  localparam int unsigned SC_W = $clog2(SETTLE_CYCLES);

  align_state_t state_q, state_d;

  logic [WIDTH*SAMPLES-1:0] aligned;
  logic [WIDTH*SAMPLES-1:0] dout_q;
  logic [WIDTH-1:0]         bit_match;
  logic                     match;
  logic [1:0]               offset_q;
  logic [1:0]               slip_cnt_q;
  logic [SC_W-1:0]          settle_cnt_q;
  logic [MC_W-1:0]          match_cnt_q;
  logic                     fail_q;
  logic                     settle_last;
  logic                     match_last;

  // Shifting the 8-sample window {din, prev} right by offset picks w[offset+s] for every s.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [2*SAMPLES-1:0] win;
    assign win = {din_word[i*SAMPLES +: SAMPLES], prev_word[i*SAMPLES +: SAMPLES]};
    assign aligned[i*SAMPLES +: SAMPLES] = SAMPLES'(win >> offset_q);
    assign bit_match[i] = (dout_q[i*SAMPLES +: SAMPLES] == TRAIN_PATTERN);
  end

  assign match       = &bit_match;
  assign settle_last = (settle_cnt_q == SC_W'(SETTLE_CYCLES - 1));
  assign match_last  = (match_cnt_q == MC_W'(MATCH_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (align_start) begin
      state_d = ST_SETTLE;
    end else begin
      case (state_q)
        ST_IDLE:   state_d = ST_IDLE;
        ST_SETTLE: if (settle_last) state_d = ST_SEARCH;
        ST_SEARCH: begin
          if (!match) begin
            state_d = ST_SLIP;
          end else if (match_last) begin
            state_d = ST_LOCKED;
          end
        end
        ST_SLIP:   state_d = ST_SETTLE;
        ST_LOCKED: state_d = ST_LOCKED;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    locked = (state_q == ST_LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q       <= '0;
      offset_q     <= '0;
      fail_q       <= 1'b0;
      slip_cnt_q   <= '0;
      settle_cnt_q <= '0;
      match_cnt_q  <= '0;
    end else begin
      dout_q <= aligned;
      if (align_start) begin
        fail_q       <= 1'b0;
        slip_cnt_q   <= '0;
        settle_cnt_q <= '0;
        match_cnt_q  <= '0;
      end else begin
        case (state_q)
          ST_SETTLE: begin
            if (settle_last) begin
              settle_cnt_q <= '0;
              match_cnt_q  <= '0;
            end else begin
              settle_cnt_q <= settle_cnt_q + SC_W'(1);
            end
          end
          ST_SEARCH: begin
            if (match) begin
              if (match_cnt_q != MC_W'(MATCH_CYCLES)) begin
                match_cnt_q <= match_cnt_q + MC_W'(1);
              end
              if (match_last) begin
                fail_q <= 1'b0;
              end
            end
          end
          ST_SLIP: begin
            offset_q     <= offset_q + 2'd1;
            settle_cnt_q <= '0;
            if (slip_cnt_q == 2'd3) begin
              fail_q     <= 1'b1;
              slip_cnt_q <= '0;
            end else begin
              slip_cnt_q <= slip_cnt_q + 2'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign dout_word = dout_q;
  assign offset    = offset_q;
  assign fail      = fail_q;

endmodule

// File: rtl/qdr_word_aligner.sv
module qdr_word_aligner
  import qdr_align_pkg::*;
#(
  parameter int unsigned CHANNELS      = 2,
  parameter int unsigned WIDTH         = 8,
  parameter logic [3:0]  TRAIN_PATTERN = 4'b0011,
  parameter int unsigned MATCH_CYCLES  = 16,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [CHANNELS*WIDTH*SAMPLES-1:0] din,
  input  logic                              align_start,
  output logic [CHANNELS*WIDTH*SAMPLES-1:0] dout,
  output logic [CHANNELS*2-1:0]             offset,
  output logic [CHANNELS-1:0]               locked,
  output logic [CHANNELS-1:0]               fail
);

  localparam int unsigned CH_BITS = WIDTH * SAMPLES;

  logic [CHANNELS*WIDTH*SAMPLES-1:0] prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= '0;
    end else begin
      prev_q <= din;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    localparam int unsigned BASE = bit_index(c, 0, 0, WIDTH);

    qdr_align_ch #(
      .WIDTH         (WIDTH),
      .TRAIN_PATTERN (TRAIN_PATTERN),
      .MATCH_CYCLES  (MATCH_CYCLES),
      .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .align_start (align_start),
      .prev_word   (prev_q[BASE +: CH_BITS]),
      .din_word    (din[BASE +: CH_BITS]),
      .dout_word   (dout[BASE +: CH_BITS]),
      .offset      (offset[c*2 +: 2]),
      .locked      (locked[c]),
      .fail        (fail[c])
    );
  end

endmodule

// File: doc/qdr_word_aligner.md
# qdr_word_aligner

Parametrised word-alignment stage that follows the differential QDR input capture. It takes four phase samples per input bit per clock (rise_0, rise_90, fall_0, fall_90), already in a single clock domain, for `CHANNELS` × `WIDTH` bits. It finds, per channel, the sample rotation that matches a training pattern and holds that rotation as lock. It then outputs aligned 4-sample words with per-channel lock, fail and offset status.

## Interface

Parameters:
- `CHANNELS`, 2: number of independently aligned channels.
- `WIDTH`, 8: data bits per channel.
- `TRAIN_PATTERN`, 4'b0011: expected time-ordered 4-sample word per bit during training. All four rotations are distinct.
- `MATCH_CYCLES`, 16: consecutive matching cycles required for lock (≥1).
- `SETTLE_CYCLES`, 4: cycles ignored after an offset change (≥2).

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1: the only clock; all logic on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `din`  in  CHANNELS·WIDTH·4: bit i of channel c, sample s at index ((c·WIDTH+i)·4)+s. s=0 rise_0, 1 rise_90, 2 fall_0, 3 fall_90, in time order.
- `align_start`  in  1: single-cycle pulse that (re)starts training on all channels.
- `dout`  out  CHANNELS·WIDTH·4: aligned samples, same index layout as `din`.
- `offset`  out  CHANNELS·2: current rotation per channel, 0..3.
- `locked`  out  CHANNELS: channel has locked.
- `fail`  out  CHANNELS: a full rotation (4 slips) has completed without lock.

## Operation

- `prev` register holds the previous `din`. Per bit, window w[0..7] = {prev s0..s3, din s0..s3}, oldest first.
- Aligned sample s = w[offset+s]. `dout` is registered.
- Offset 0 therefore outputs `prev` unchanged. Each offset increment delays the word by one quarter-period.
- A channel "matches" in a cycle when every one of its WIDTH bits has `dout` samples equal to `TRAIN_PATTERN` (bit s ↔ sample s).
- Per-channel FSM:
  - IDLE: after reset; no action until `align_start`.
  - SETTLE: count SETTLE_CYCLES, then go to SEARCH with the match count cleared.
  - SEARCH: on a match, increment the match count. At MATCH_CYCLES go to LOCKED.
  - SEARCH, on a mismatch: go to SLIP.
  - SLIP (1 cycle): offset ← (offset+1) mod 4, slip count +1. If the slip count reaches 4, set `fail` and clear the slip count. Go to SETTLE.
  - LOCKED: hold offset; data is not monitored; `locked`=1.
- `align_start` in any state except during `rst`:
  - clears `locked`, `fail`, slip count and match count;
  - keeps `offset`;
  - goes to SETTLE on the next edge.
- `fail` stays asserted while the search continues. It clears on lock or on `align_start`.
- Channels run fully independently; only `align_start` and `rst` are shared.

## Timing

- Reset values:
  - `dout` = 0, `offset` = 0, `locked` = 0, `fail` = 0.
  - `prev` = 0; FSM in IDLE; all counters 0.
- `rst` has priority over `align_start` in the same cycle.
- Data latency is 2 cycles. `din` at edge t appears in `dout` after edge t+2 for offset 0. Offsets 1..3 mix in samples from the word at t+1.
- An offset change is visible in `dout` 1 cycle after SLIP. SETTLE_CYCLES ≥ 2 guarantees SEARCH sees only post-slip data.
- Minimum time from `align_start` to `locked` with correct initial offset: 1 + SETTLE_CYCLES + MATCH_CYCLES cycles.
- A single mismatching cycle in SEARCH always causes a slip; there is no tolerance.
- Match count saturates at MATCH_CYCLES.

## Structure

- Package `qdr_align_pkg` holds:
  - FSM state encoding (IDLE, SETTLE, SEARCH, SLIP, LOCKED);
  - sample-index constants S_RISE0..S_FALL90;
  - the function mapping (c, i, s) → bit index.
- Sub-module `qdr_align_ch` implements one channel (window mux, match detect, FSM, counters). The top level generates `CHANNELS` instances and shares `prev` slicing.

## Test plan

- Reset then idle: `rst` for 3 cycles with random `din` → all outputs 0, `locked`=0 indefinitely with no `align_start`.
- Aligned training: drive pattern 0011 on every bit with true rotation 0, pulse `align_start` → `offset`=0, `locked`=1 exactly 1+4+16 cycles later.
- Rotated training: channel 0 receives rotation 2 (1100 source phase), channel 1 rotation 0 → ch0 locks at `offset`=2 after 2 slips, ch1 at `offset`=0, at independent times.
- No pattern: constant 0 on channel 0 → `fail` rises after the 4th slip, `offset` wraps 3→0, search continues. Apply the correct pattern → lock, `fail` clears.
- Restart mid-search: `align_start` during SEARCH at `offset`=1 → counters cleared, `offset` stays 1, SETTLE restarts. `rst` in the same cycle as `align_start` → reset values win.
- Post-lock data: after lock at `offset`=3, drive a known incrementing sample stream → `dout` equals the 3-sample-shifted stream with 2-cycle latency, and lock is held through mismatches.
